logic_unit_seq: RTL and testbench

Parametrised, multi-cycle bitwise logic unit with zero-detect reduction. It processes a WIDTH-bit operand pair in CHUNK-bit slices, one slice per clock, under a START/BUSY/DONE handshake. It generalises the fixed 32-bit gate arrays and chained OR-reduction trees into one configurable block for the datapath and its multi-cycle control.

---
 rtl/logic_unit_seq_pkg.sv | 23 ++
 rtl/logic_unit_seq_if.sv | 17 +
 rtl/logic_unit_seq_chunk.sv | 33 +++
 rtl/logic_unit_seq.sv | 89 ++++++++
 tb/tb_logic_unit_seq.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/logic_unit_seq_pkg.sv
// Shared definitions for the sequential logic unit: opcodes, FSM states and
// the opcode legality check. Optional macro: LOGIC_UNIT_XOR_EN (XOR/XNOR).
package logic_unit_pkg;

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_NOR  = 3'b010;
   localparam logic [2:0] OP_NOT  = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_XNOR = 3'b101;

   typedef enum logic [1:0] {IDLE, RUN, DONE_S} state_t;

   // Opcodes 110/111 are always reserved; 100/101 only exist with the XOR build.
   function automatic logic op_legal(input logic [2:0] op);
`ifdef LOGIC_UNIT_XOR_EN
      return (op <= OP_XNOR);
`else
      return (op <= OP_NOT);
`endif
   endfunction

endpackage

// File: rtl/logic_unit_seq_if.sv
// Request/response bundle of the sequential logic unit.
interface logic_unit_seq_if #(
   parameter int WIDTH = 32
);
   logic             START;
   logic [2:0]       OPCODE;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             BUSY;
   logic             DONE;
   logic [WIDTH-1:0] Y;
   logic             Z;
   logic             ERR;

   modport master (output START, OPCODE, A, B, input BUSY, DONE, Y, Z, ERR);
   modport slave  (input START, OPCODE, A, B, output BUSY, DONE, Y, Z, ERR);
endinterface

// File: rtl/logic_unit_seq_chunk.sv
// One CHUNK-bit slice of the bitwise datapath plus its zero flag.
// Optional macro: LOGIC_UNIT_XOR_EN adds XOR/XNOR decode.
module logic_chunk
   import logic_unit_pkg::*;
#(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a_i,
   input  logic [CHUNK-1:0] b_i,
   input  logic [2:0]       op_i,
   output logic [CHUNK-1:0] res_o,
   output logic             slice_zero_o
);

   // Opcode decode; anything not decoded (reserved or disabled) yields zero.
   always_comb begin
      res_o = '0;
      case (op_i)
         OP_AND:  res_o = a_i & b_i;
         OP_OR:   res_o = a_i | b_i;
         OP_NOR:  res_o = ~(a_i | b_i);
         OP_NOT:  res_o = ~a_i;
`ifdef LOGIC_UNIT_XOR_EN
         OP_XOR:  res_o = a_i ^ b_i;
         OP_XNOR: res_o = ~(a_i ^ b_i);
`endif
         default: res_o = '0;
      endcase
   end

   assign slice_zero_o = (res_o == '0);

endmodule

// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise logic unit: one CHUNK slice per clock, LSB slice first,
// START/BUSY/DONE handshake, zero-detect accumulated across slices.
// Optional macro: LOGIC_UNIT_XOR_EN enables opcodes 100 (XOR) and 101 (XNOR).
module logic_unit_seq
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             CLK,
   input  logic             RST,
   logic_unit_seq_if.slave  bus
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

   state_t                        state_q;
   logic [CW-1:0]                 cnt_q;
   logic [NCHUNK-1:0][CHUNK-1:0]  a_q, b_q, y_q;
   logic [2:0]                    op_q;
   logic                          zacc_q, z_q, err_q, busy_q, done_q;

   logic [CHUNK-1:0]              slice_res;
   logic                          slice_zero;
   logic                          accept;

   // Single slice datapath, time-multiplexed by the slice counter.
   logic_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a_i          (a_q[cnt_q]),
      .b_i          (b_q[cnt_q]),
      .op_i         (op_q),
      .res_o        (slice_res),
      .slice_zero_o (slice_zero)
   );

   // A new request is taken whenever the unit is not running.
   assign accept = bus.START && (state_q != RUN);

   // Control FSM and all registered outputs.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         y_q     <= '0;
         op_q    <= OP_AND;
         zacc_q  <= 1'b1;
         z_q     <= 1'b1;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (state_q == RUN) begin
            y_q[cnt_q] <= slice_res;
            zacc_q     <= zacc_q & slice_zero;
            if (cnt_q == LAST) begin
               state_q <= DONE_S;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               z_q     <= zacc_q & slice_zero;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end else if (accept) begin
            state_q <= RUN;
            a_q     <= bus.A;
            b_q     <= bus.B;
            op_q    <= bus.OPCODE;
            cnt_q   <= '0;
            zacc_q  <= 1'b1;
            err_q   <= ~op_legal(bus.OPCODE);
            busy_q  <= 1'b1;
         end else begin
            state_q <= IDLE;
         end
      end
   end

   assign bus.BUSY = busy_q;
   assign bus.DONE = done_q;
   assign bus.Y    = y_q;
   assign bus.Z    = z_q;
   assign bus.ERR  = err_q;

endmodule

// File: tb/tb_logic_unit_seq.sv
// Self-checking bench for logic_unit_seq: directed scenarios plus random
// operations against a whole-word behavioural model.
module tb_logic_unit_seq;

   localparam int WIDTH  = 32;
   localparam int CHUNK  = 8;
   localparam int NCHUNK = WIDTH / CHUNK;
`ifdef LOGIC_UNIT_XOR_EN
   localparam bit XOR_EN = 1'b1;
`else
   localparam bit XOR_EN = 1'b0;
`endif

   logic CLK;
   logic RST;
   int   total;
   int   bad;

   logic_unit_seq_if #(.WIDTH(WIDTH)) bus ();

   logic_unit_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Reference model: whole-word result of one request.
   function automatic bit m_legal(input logic [2:0] op);
      return (op <= 3'd3) || (XOR_EN && (op == 3'd4 || op == 3'd5));
   endfunction

   function automatic logic [WIDTH-1:0] m_y(input logic [2:0] op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
      if (!m_legal(op)) return '0;
      case (op)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return ~(a | b);
         3'd3:    return ~a;
         3'd4:    return a ^ b;
         default: return ~(a ^ b);
      endcase
   endfunction

   // Present a request for one clock edge; called and returns at a negedge.
   task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b);
      bus.START  = 1'b1;
      bus.OPCODE = op;
      bus.A      = a;
      bus.B      = b;
      @(posedge CLK);
      @(negedge CLK);
      bus.START  = 1'b0;
   endtask

   // Count negedges until DONE, bounded; also counts BUSY-high samples.
   task automatic wait_done(output int cyc, output int bcnt);
      cyc  = 0;
      bcnt = 0;
      while (bus.DONE !== 1'b1 && cyc < 20) begin
         if (bus.BUSY === 1'b1) bcnt++;
         @(negedge CLK);
         cyc++;
      end
   endtask

   task automatic test_reset();
      RST = 1'b0;
      #3;
      total++;
      if ({bus.BUSY, bus.DONE, bus.Y, bus.Z, bus.ERR} !== {1'b0, 1'b0, 32'h0, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL reset: got busy=%b done=%b y=%h z=%b err=%b, need 0 0 0 1 0",
                  bus.BUSY, bus.DONE, bus.Y, bus.Z, bus.ERR);
      end
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
   endtask

   task automatic test_and();
      int cyc, bcnt;
      issue(3'd0, 32'hFFFF0000, 32'h0F0F0F0F);
      wait_done(cyc, bcnt);
      total++;
      if (cyc != NCHUNK || bcnt != NCHUNK) begin
         bad++;
         $display("FAIL and_timing: got latency=%0d busy=%0d, need %0d %0d", cyc, bcnt, NCHUNK, NCHUNK);
      end
      total++;
      if ({bus.Y, bus.Z, bus.ERR} !== {32'h0F0F0000, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL and_result: got y=%h z=%b err=%b, need 0f0f0000 0 0", bus.Y, bus.Z, bus.ERR);
      end
      repeat (3) @(negedge CLK);
      total++;
      if ({bus.DONE, bus.BUSY, bus.Y, bus.Z} !== {1'b0, 1'b0, 32'h0F0F0000, 1'b0}) begin
         bad++;
         $display("FAIL and_hold: got done=%b busy=%b y=%h z=%b, need 0 0 0f0f0000 0",
                  bus.DONE, bus.BUSY, bus.Y, bus.Z);
      end
   endtask

   task automatic test_back_to_back();
      int cyc, bcnt;
      issue(3'd2, 32'hFFFFFFFF, 32'h00000000);
      wait_done(cyc, bcnt);
      total++;
      if ({bus.DONE, bus.Y, bus.Z} !== {1'b1, 32'h0, 1'b1}) begin
         bad++;
         $display("FAIL nor_result: got done=%b y=%h z=%b, need 1 0 1", bus.DONE, bus.Y, bus.Z);
      end
      issue(3'd3, 32'h12345678, 32'hDEADBEEF);
      total++;
      if (bus.BUSY !== 1'b1 || bus.DONE !== 1'b0) begin
         bad++;
         $display("FAIL b2b_accept: got busy=%b done=%b, need 1 0", bus.BUSY, bus.DONE);
      end
      wait_done(cyc, bcnt);
      total++;
      if (cyc != NCHUNK || {bus.Y, bus.Z, bus.ERR} !== {32'hEDCBA987, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL not_b2b: got latency=%0d y=%h z=%b err=%b, need %0d edcba987 0 0",
                  cyc, bus.Y, bus.Z, bus.ERR, NCHUNK);
      end
      @(negedge CLK);
   endtask

   task automatic test_busy_ignore();
      int cyc, bcnt, extra;
      issue(3'd1, 32'h0000000F, 32'h000000F0);
      @(negedge CLK);
      issue(3'd1, 32'hFFFFFFFF, 32'h000000F0);
      wait_done(cyc, bcnt);
      total++;
      if (cyc != NCHUNK - 2 || bus.Y !== 32'h000000FF || bus.Z !== 1'b0) begin
         bad++;
         $display("FAIL busy_ignore: got wait=%0d y=%h z=%b, need %0d 000000ff 0",
                  cyc, bus.Y, bus.Z, NCHUNK - 2);
      end
      extra = 0;
      repeat (8) begin
         @(negedge CLK);
         if (bus.DONE === 1'b1 || bus.BUSY === 1'b1) extra++;
      end
      total++;
      if (extra != 0) begin
         bad++;
         $display("FAIL busy_ignore_extra: got %0d busy/done samples after result, need 0", extra);
      end
   endtask

   task automatic test_xor();
      int cyc, bcnt;
      issue(3'd4, 32'hA5A5A5A5, 32'hA5A5A5A5);
      wait_done(cyc, bcnt);
      total++;
      if (cyc != NCHUNK || {bus.Y, bus.Z, bus.ERR} !== {32'h0, 1'b1, !XOR_EN}) begin
         bad++;
         $display("FAIL xor: got latency=%0d y=%h z=%b err=%b, need %0d 0 1 %b",
                  cyc, bus.Y, bus.Z, bus.ERR, NCHUNK, !XOR_EN);
      end
      issue(3'd7, 32'h12345678, 32'h0000FFFF);
      total++;
      if (bus.ERR !== 1'b1) begin
         bad++;
         $display("FAIL op7_err_early: got err=%b, need 1", bus.ERR);
      end
      wait_done(cyc, bcnt);
      total++;
      if (cyc != NCHUNK || {bus.Y, bus.Z, bus.ERR} !== {32'h0, 1'b1, 1'b1}) begin
         bad++;
         $display("FAIL op7: got latency=%0d y=%h z=%b err=%b, need %0d 0 1 1",
                  cyc, bus.Y, bus.Z, bus.ERR, NCHUNK);
      end
      @(negedge CLK);
   endtask

   task automatic test_abort();
      int cyc, bcnt, seen;
      issue(3'd1, 32'h11111111, 32'h22222222);
      @(negedge CLK);
      RST = 1'b0;
      #1;
      total++;
      if ({bus.BUSY, bus.DONE, bus.Y, bus.Z, bus.ERR} !== {1'b0, 1'b0, 32'h0, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL abort_reset: got busy=%b done=%b y=%h z=%b err=%b, need 0 0 0 1 0",
                  bus.BUSY, bus.DONE, bus.Y, bus.Z, bus.ERR);
      end
      @(negedge CLK);
      RST  = 1'b1;
      seen = 0;
      repeat (8) begin
         @(negedge CLK);
         if (bus.DONE === 1'b1) seen++;
      end
      total++;
      if (seen != 0) begin
         bad++;
         $display("FAIL abort_no_done: got %0d DONE pulses, need 0", seen);
      end
      issue(3'd0, 32'hCAFEF00D, 32'hFFFF00FF);
      wait_done(cyc, bcnt);
      total++;
      if (cyc != NCHUNK || bus.Y !== 32'hCAFE000D || bus.ERR !== 1'b0) begin
         bad++;
         $display("FAIL abort_recover: got latency=%0d y=%h err=%b, need %0d cafe000d 0",
                  cyc, bus.Y, bus.ERR, NCHUNK);
      end
      @(negedge CLK);
   endtask

   task automatic test_random();
      int cyc, bcnt;
      logic [2:0]       op;
      logic [WIDTH-1:0] a, b, ey;
      for (int i = 0; i < 40; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = $urandom;
         if (i % 8 == 0) b = a;
         if (i % 8 == 1) a = '0;
         ey = m_y(op, a, b);
         issue(op, a, b);
         total++;
         if (bus.ERR !== !m_legal(op)) begin
            bad++;
            $display("FAIL rand_err_early[%0d]: op=%0d got err=%b, need %b", i, op, bus.ERR, !m_legal(op));
         end
         wait_done(cyc, bcnt);
         total++;
         if (cyc != NCHUNK || bcnt != NCHUNK || bus.Y !== ey || bus.Z !== (ey == '0)
             || bus.ERR !== !m_legal(op)) begin
            bad++;
            $display("FAIL rand[%0d]: op=%0d a=%h b=%h got lat=%0d busy=%0d y=%h z=%b err=%b, need %0d %0d %h %b %b",
                     i, op, a, b, cyc, bcnt, bus.Y, bus.Z, bus.ERR, NCHUNK, NCHUNK, ey, (ey == '0), !m_legal(op));
         end
         if ($urandom_range(0, 1) == 0) @(negedge CLK);
      end
      @(negedge CLK);
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      RST        = 1'b0;
      bus.START  = 1'b0;
      bus.OPCODE = 3'd0;
      bus.A      = '0;
      bus.B      = '0;
      @(negedge CLK);
      test_reset();
      test_and();
      test_back_to_back();
      test_busy_ignore();
      test_xor();
      test_abort();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
